// File: rtl/aes_sched_pkg.sv
// ============================================================================
// Module   : aes_sched_pkg
// Brief    : Shared constants and tag type for the AES stage-three scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_sched_pkg;

    localparam int c_NUM_REQ_DEF   = 2;
    localparam int c_PIPE_LAT_DEF  = 4;
    localparam int c_RSP_DEPTH_DEF = 4;
    localparam int c_BLK_W         = 128;
    // Tag id is sized for up to 256 requesters; the top uses the low bits.
    localparam int c_TAG_ID_W      = 8;

    typedef struct packed {
        logic                  live;
        logic [c_TAG_ID_W-1:0] id;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/aes_rsp_fifo.sv
// ============================================================================
// Module   : aes_rsp_fifo
// Brief    : First-word fall-through response FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 129,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int               c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = push && !w_full;
    assign w_pop   = pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally left without reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(push && w_full));

endmodule

`default_nettype wire

// File: rtl/aes_stage_sched.sv
// ============================================================================
// Module   : aes_stage_sched
// Brief    : Round-robin scheduler sharing one fixed-latency AES pipeline
//            among several requesters, with credit-based response buffering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_stage_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ   = c_NUM_REQ_DEF,
    parameter int PIPE_LAT  = c_PIPE_LAT_DEF,
    parameter int RSP_DEPTH = c_RSP_DEPTH_DEF
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][c_BLK_W-1:0]         req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic [c_BLK_W-1:0]                      pipe_data_in,
    output logic                                    pipe_issue,
    input  logic [c_BLK_W-1:0]                      pipe_data_out,
    output logic                                    rsp_valid,
    output logic [c_BLK_W-1:0]                      rsp_data,
    output logic [$clog2(NUM_REQ > 1 ? NUM_REQ : 2)-1:0] rsp_id,
    input  logic                                    rsp_ready,
    output logic                                    busy
);

    localparam int c_ID_W  = $clog2(NUM_REQ > 1 ? NUM_REQ : 2);
    localparam int c_INF_W = $clog2(PIPE_LAT + 1);
    localparam int c_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int c_ENT_W = c_ID_W + c_BLK_W;

    tag_t               r_tag [PIPE_LAT];
    logic [c_ID_W-1:0]  r_last;
    logic [c_ID_W-1:0]  w_winner;
    logic               w_found;
    logic [c_INF_W-1:0] w_inflight;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic [c_ENT_W-1:0] w_head;
    logic               w_rsp_pop;
    logic               w_issue_ok;
    logic               w_grant;
    logic               w_unused_tag;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int                v_idx;
        logic [c_ID_W-1:0] v_sel;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = (int'(r_last) + 1 + k) % NUM_REQ;
            v_sel = c_ID_W'(v_idx);
            if (!w_found && req_valid[v_sel]) begin
                w_found  = 1'b1;
                w_winner = v_sel;
            end
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < PIPE_LAT; k++) begin
            w_inflight = w_inflight + c_INF_W'(r_tag[k].live);
        end
    end

    assign w_rsp_pop  = rsp_valid && rsp_ready;
    // Credit check: every block issued now is guaranteed a FIFO slot on arrival.
    assign w_issue_ok = (int'(w_inflight) + int'(w_fifo_count) - int'(w_rsp_pop)) < RSP_DEPTH;
    assign w_grant    = !rst && w_found && w_issue_ok;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign pipe_issue   = w_grant;
    assign pipe_data_in = w_grant ? req_data[w_winner] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= c_ID_W'(NUM_REQ - 1);
        end else if (w_grant) begin
            r_last <= w_winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0].live <= w_grant;
            r_tag[0].id   <= c_TAG_ID_W'(w_winner);
            for (int s = 1; s < PIPE_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_unused_tag = ^r_tag[PIPE_LAT-1].id;

    aes_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (c_ENT_W),
        .CNT_W (c_CNT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_tag[PIPE_LAT-1].live),
        .push_data ({r_tag[PIPE_LAT-1].id[c_ID_W-1:0], pipe_data_out}),
        .pop       (w_rsp_pop),
        .head_data (w_head),
        .count     (w_fifo_count)
    );

    assign rsp_valid = !rst && (w_fifo_count != '0);
    assign rsp_data  = rst ? '0 : w_head[c_BLK_W-1:0];
    assign rsp_id    = rst ? '0 : w_head[c_ENT_W-1:c_BLK_W];
    assign busy      = !rst && ((w_inflight != '0) || (w_fifo_count != '0));

endmodule

`default_nettype wire

// File: tb/tb_aes_stage_sched.sv
// ============================================================================
// Module   : tb_aes_stage_sched
// Brief    : Self-checking bench for aes_stage_sched against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_stage_sched;

    localparam int NUM_REQ   = 2;
    localparam int PIPE_LAT  = 4;
    localparam int RSP_DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0][127:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [127:0]              pipe_data_in;
    logic                      pipe_issue;
    logic [127:0]              pipe_data_out;
    logic                      rsp_valid;
    logic [127:0]              rsp_data;
    logic [0:0]                rsp_id;
    logic                      rsp_ready;
    logic                      busy;

    aes_stage_sched #(
        .NUM_REQ   (NUM_REQ),
        .PIPE_LAT  (PIPE_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .pipe_data_in  (pipe_data_in),
        .pipe_issue    (pipe_issue),
        .pipe_data_out (pipe_data_out),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_id        (rsp_id),
        .rsp_ready     (rsp_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] xform(input logic [127:0] x);
        return {x[63:0], x[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    endfunction

    // Stand-in for the shared round pipeline: plain delay plus a fixed transform.
    logic [127:0] pipe_q [PIPE_LAT];
    always @(posedge clk) begin
        pipe_q[0] <= pipe_data_in;
        for (int k = 1; k < PIPE_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
    assign pipe_data_out = xform(pipe_q[PIPE_LAT-1]);

    typedef struct {
        int           id;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   last_gnt = NUM_REQ - 1;
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: inputs are already driven; compare at the falling edge,
    // then advance the model as of the following rising edge.
    task automatic cycle();
        int                 win;
        int                 j;
        bit                 exp_rv;
        bit                 do_pop;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [127:0]       exp_pdi;
        @(negedge clk);
        if (rst) begin
            chk("rst_req_ready", 128'(req_ready), 128'd0);
            chk("rst_pipe_issue", 128'(pipe_issue), 128'd0);
            chk("rst_pipe_data_in", pipe_data_in, 128'd0);
            chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
            chk("rst_rsp_data", rsp_data, 128'd0);
            chk("rst_rsp_id", 128'(rsp_id), 128'd0);
            chk("rst_busy", 128'(busy), 128'd0);
            exp_q.delete();
            last_gnt = NUM_REQ - 1;
        end else begin
            exp_rv = (exp_q.size() > 0) && (cyc >= exp_q[0].cyc + PIPE_LAT + 1);
            do_pop = exp_rv && rsp_ready;
            win = -1;
            if (exp_q.size() - int'(do_pop) < RSP_DEPTH) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (last_gnt + 1 + k) % NUM_REQ;
                    if (win < 0 && req_valid[j]) win = j;
                end
            end
            exp_rdy = '0;
            exp_pdi = '0;
            if (win >= 0) begin
                exp_rdy[win] = 1'b1;
                exp_pdi      = req_data[win];
            end
            chk("req_ready", 128'(req_ready), 128'(exp_rdy));
            chk("pipe_issue", 128'(pipe_issue), 128'(win >= 0));
            chk("pipe_data_in", pipe_data_in, exp_pdi);
            chk("rsp_valid", 128'(rsp_valid), 128'(exp_rv));
            chk("busy", 128'(busy), 128'(exp_q.size() != 0));
            if (do_pop) begin
                chk("rsp_id", 128'(rsp_id), 128'(exp_q[0].id));
                chk("rsp_data", rsp_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (win >= 0) begin
                exp_q.push_back('{id: win, data: xform(req_data[win]), cyc: cyc});
                last_gnt = win;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] vld, input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = vld;
            rsp_ready = rdy;
            for (int r = 0; r < NUM_REQ; r++) req_data[r] = rand128();
            cycle();
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        #1;
        drive(2'b11, 1'b1, 2);
        rst = 1'b0;

        // Single request with a known block.
        req_valid   = 2'b01;
        req_data[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        rsp_ready   = 1'b1;
        cycle();
        drive(2'b00, 1'b1, 8);

        // Fairness: both requesters continuously valid.
        drive(2'b11, 1'b1, 8);
        drive(2'b00, 1'b1, 8);

        // Backpressure; the release cycle hits 3 buffered + 1 in flight + 1 pop.
        drive(2'b11, 1'b0, 7);
        drive(2'b11, 1'b1, 6);
        drive(2'b00, 1'b1, 10);

        // Reset two cycles after the last of three issues.
        drive(2'b01, 1'b1, 3);
        drive(2'b00, 1'b1, 1);
        rst = 1'b1;
        drive(2'b00, 1'b1, 1);
        rst = 1'b0;
        drive(2'b00, 1'b1, 9);
        drive(2'b11, 1'b1, 1);
        drive(2'b00, 1'b1, 8);

        // Random soak.
        for (int i = 0; i < 10000; i++) begin
            drive(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0), 1);
        end
        drive(2'b00, 1'b1, 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
